// File: rtl/regfile_mp_if.sv
// Register-file port bundle: decode-side reads and reservations, writeback-side
// writes, and the registered write-conflict flag.
//   master : decode/writeback side (drives enables, addresses, write data)
//   slave  : register file (returns read data, busy flags, wr_conflict)
interface regfile_mp_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2
);
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic                     wr_conflict;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, wr_conflict
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, wr_conflict
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_mp_if.slave
//     rd_en/rd_addr -> rd_data/rd_busy  combinational reads (optional bypass)
//     wr_en/wr_addr/wr_data             writes on the rising edge, highest port wins
//     rsv_en/rsv_addr                   mark a destination busy (beats same-cycle write)
//     wr_conflict                       registered: >=2 enabled write ports shared an address
module regfile_mp #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_mp_if.slave bus
);

   logic [DATA_W-1:0]        mem_q [NUM_REGS];
   logic [DATA_W-1:0]        mem_d [NUM_REGS];
   logic [NUM_REGS-1:0]      busy_q;
   logic [NUM_REGS-1:0]      busy_d;
   logic                     conflict_q;
   logic                     conflict_d;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   // Register 0 is dead storage when hardwired to zero.
   function automatic logic reg_live(input int unsigned r);
      return (ZERO_REG == 0) || (r != 0);
   endfunction

   // Next state: address-decoded per register, so out-of-range addresses
   // simply never match. Ascending port order makes the highest port win,
   // and the reservation is applied last so it beats a same-cycle write.
   always_comb begin
      mem_d      = mem_q;
      busy_d     = busy_q;
      conflict_d = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (reg_live(r)) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
               if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                  mem_d[r]  = bus.wr_data[j*DATA_W +: DATA_W];
                  busy_d[r] = 1'b0;
               end
            end
            if (bus.rsv_en && (bus.rsv_addr == ADDR_W'(r))) begin
               busy_d[r] = 1'b1;
            end
         end
      end
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         for (int unsigned k = j + 1; k < NUM_WR; k++) begin
            if (bus.wr_en[j] && bus.wr_en[k] &&
                (bus.wr_addr[j*ADDR_W +: ADDR_W] == bus.wr_addr[k*ADDR_W +: ADDR_W])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Read ports: stored value, overridden by the winning same-cycle write
   // when bypass is enabled (the forwarded value is no longer busy).
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (bus.rd_en[i]) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
               if (reg_live(r) && (bus.rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                  rd_data_c[i*DATA_W +: DATA_W] = mem_q[r];
                  rd_busy_c[i]                  = busy_q[r];
                  if (BYPASS != 0) begin
                     for (int unsigned j = 0; j < NUM_WR; j++) begin
                        if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                           rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
                           rd_busy_c[i]                  = 1'b0;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            mem_q[r] <= '0;
         end
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign bus.rd_data     = rd_data_c;
   assign bus.rd_busy     = rd_busy_c;
   assign bus.wr_conflict = conflict_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-ported integer register file, successor to the single-write/dual-read CPU register file.
- Configurable read-port and write-port counts, width and depth.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard (reserve on issue, clear on writeback) for the decode/hazard stage.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 32, register data width
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data (combinational)
rd_busy  output  NUM_RD  addressed register has an outstanding reservation (combinational)
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  packed write addresses
wr_data  input  NUM_WR*DATA_W  packed write data
rsv_en  input  1  reserve (mark busy) one destination register
rsv_addr  input  ADDR_W  register to reserve
wr_conflict  output  1  registered flag: >=2 write ports hit the same address in the previous cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, wr_conflict = 0. Takes effect immediately, even mid-write; the first rising edge after deassertion performs normal updates.
- Write, rising edge: for each wr_en[j] with wr_addr[j] < NUM_REGS, mem[addr] <= wr_data[j].
- Same-address writes in one cycle: the highest-index port wins. wr_conflict <= 1 for exactly the next cycle, else 0.
- Out-of-range addresses (>= NUM_REGS): write ignored; read returns 0 with rd_busy = 0.
- ZERO_REG=1, address 0: writes ignored, reads 0, reservations ignored, busy bit never set.
- Read, combinational per port i:
  - rd_en[i] = 0: rd_data = 0, rd_busy = 0.
  - BYPASS=1 and some wr_en[j] targets rd_addr[i] (same priority rule): returns that wr_data. Otherwise returns mem[rd_addr[i]].
  - Write-then-read: the write completes at edge N; the value is visible from cycle N+1, and in cycle N when BYPASS=1.
- Scoreboard, rising edge:
  - busy[rsv_addr] <= 1 when rsv_en.
  - busy[a] <= 0 when any write port writes a.
  - Reserve and write to the same address in one cycle: reserve wins, busy stays 1 (new producer supersedes old).
  - Re-reserving an already busy register: busy stays 1; no counting.
- rd_busy[i] = busy[rd_addr[i]], except 0 when BYPASS=1 and a same-cycle write to that address is forwarded.
- No backpressure, no handshake: every enabled operation completes in its cycle.
- Latency: read 0 cycles (combinational); write/scoreboard update 1 edge; wr_conflict 1 cycle after the offending writes.

Test Plan:
1. Reset with mem pre-written, assert rst_n=0 mid-cycle -> rd_data of every port = 0 immediately, rd_busy = 0, wr_conflict = 0.
2. wr_en=01, wr_addr0=5, wr_data0=0xDEADBEEF, rd_addr0=5 same cycle, BYPASS=1 -> rd_data0=0xDEADBEEF in that cycle. With BYPASS=0 -> old value (0) that cycle, 0xDEADBEEF next cycle.
3. Both write ports to addr 7 (port0 0x11, port1 0x22) -> mem[7]=0x22 after the edge; wr_conflict=1 for exactly one cycle, then 0.
4. Write 0x1234 to addr 0 with ZERO_REG=1 -> read addr 0 returns 0. rsv_en to addr 0 -> rd_busy stays 0.
5. rsv_en addr 9 -> rd_busy=1 next cycle. Write addr 9 = 0x55 -> rd_busy=0 after the edge, and 0 during the write cycle via bypass. Simultaneous rsv and write to 9 -> busy remains 1, mem[9] updated.
6. NUM_RD=4, NUM_WR=3, DATA_W=64: random write/read/reserve traffic checked against a reference model for 10k cycles with random async resets -> zero mismatches.
